btb_predictor: RTL and testbench

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/btb_predictor.sv | 112 +++++++++++
 tb/tb_btb_predictor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction.
// Lookup is combinational off registered state; resolution drives recovery and table training.
module btb_predictor #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 8,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   cur_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_pc,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_pc,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [PC_W-1:0]   recover_pc,
    output logic [STAT_W-1:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [STAT_W-1:0]  mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic [PC_W-1:0]  correct_pc;
    logic             wr_en;
    logic [CNT_W-1:0] cnt_d;
    logic [PC_W-1:0]  tgt_d;

    // Fetch-side lookup
    always_comb begin
        lk_idx     = cur_pc[IDX_W-1:0];
        lk_tag     = cur_pc[PC_W-1:IDX_W];
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];
        pred_pc    = pred_taken ? tgt_q[lk_idx] : cur_pc + PC_W'(1);
    end

    // Resolution: recovery, mispredict detect and the single-entry write
    always_comb begin
        upd_idx    = upd_pc[IDX_W-1:0];
        upd_tag    = upd_pc[PC_W-1:IDX_W];
        upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        correct_pc = upd_taken ? upd_target : upd_pc + PC_W'(1);
        recover_pc = correct_pc;
        mispredict = upd_valid && (upd_pred_pc != correct_pc);
        mis_cnt_d  = (mispredict && (mis_cnt_q != '1)) ? mis_cnt_q + STAT_W'(1) : mis_cnt_q;

        wr_en = 1'b0;
        cnt_d = cnt_q[upd_idx];
        tgt_d = tgt_q[upd_idx];
        if (upd_valid && !flush_all) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    tgt_d = upd_target;
                    if (cnt_q[upd_idx] != CNT_MAX) cnt_d = cnt_q[upd_idx] + CNT_W'(1);
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d = cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                // Allocate weakly taken; not-taken misses never allocate
                wr_en = 1'b1;
                tgt_d = upd_target;
                cnt_d = CNT_WEAK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            mis_cnt_q <= mis_cnt_d;
            if (flush_all) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= tgt_d;
                cnt_q[upd_idx]   <= cnt_d;
            end
        end
    end

    assign mispredict_cnt = mis_cnt_q;

    // Carried for pipeline symmetry; the next-PC compare already covers direction
    logic unused_ok;
    assign unused_ok = upd_pred_taken;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (PC_W=16, ENTRIES=8, CNT_W=2).
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cur_pc;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_pc;
    logic        flush_all;
    logic        mispredict;
    logic [15:0] recover_pc;
    logic [15:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    btb_predictor #(.PC_W(16), .ENTRIES(8), .CNT_W(2), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .cur_pc(cur_pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc), .flush_all(flush_all),
        .mispredict(mispredict), .recover_pc(recover_pc), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [15:0] pc, input logic tk,
                       input logic [15:0] tgt, input logic [15:0] ppc);
        upd_valid      = v;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_pc    = ppc;
        upd_pred_taken = (ppc != pc + 16'd1);
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic exp_t,
                        input logic [15:0] exp_pc);
        cur_pc = pc;
        #1;
        chk({tag, "_taken"}, pred_taken, exp_t);
        chk({tag, "_pc"}, pred_pc, exp_pc);
    endtask

    initial begin
        rst = 1'b0;
        flush_all = 1'b0;
        cur_pc = 16'h0;
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        #2;
        chk("rst_cnt", mispredict_cnt, 16'd0);
        look("rst_look", 16'h0010, 1'b0, 16'h0011);
        #15 rst = 1'b1;
        tick();

        // Post-reset lookups, including PC wrap
        look("init_10", 16'h0010, 1'b0, 16'h0011);
        look("init_ffff", 16'hFFFF, 1'b0, 16'h0000);
        upd(1'b0, 16'h0012, 1'b1, 16'h0040, 16'h0013);
        #1 chk("novalid_mp", mispredict, 1'b0);

        // Allocate 0x0012 -> 0x0040 (mispredicted)
        upd(1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0013);
        #1 chk("alloc_mp", mispredict, 1'b1);
        chk("alloc_rec", recover_pc, 16'h0040);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("alloc_hit", 16'h0012, 1'b1, 16'h0040);
        chk("alloc_cnt", mispredict_cnt, 16'd1);

        // Three correctly predicted taken updates: counter 2 -> 3 (saturates)
        for (int i = 0; i < 3; i++) begin
            upd(1'b1, 16'h0012, 1'b1, 16'h0040, 16'h0040);
            #1 chk("tk_mp", mispredict, 1'b0);
            tick();
        end
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk("tk_cnt", mispredict_cnt, 16'd1);

        // Not-taken, fetch predicted taken: mispredict, counter 3 -> 2
        upd(1'b1, 16'h0012, 1'b0, 16'h0, 16'h0040);
        #1 chk("nt1_mp", mispredict, 1'b1);
        chk("nt1_rec", recover_pc, 16'h0013);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("nt1_look", 16'h0012, 1'b1, 16'h0040);
        // Not-taken, correctly predicted: counter 2 -> 1
        upd(1'b1, 16'h0012, 1'b0, 16'h0, 16'h0013);
        #1 chk("nt2_mp", mispredict, 1'b0);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("nt2_look", 16'h0012, 1'b0, 16'h0013);
        chk("nt_cnt", mispredict_cnt, 16'd2);

        // Aliasing at index 2
        look("alias_miss", 16'h001A, 1'b0, 16'h001B);
        upd(1'b1, 16'h001A, 1'b1, 16'h0080, 16'h001B);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("alias_old", 16'h0012, 1'b0, 16'h0013);
        look("alias_new", 16'h001A, 1'b1, 16'h0080);
        chk("alias_cnt", mispredict_cnt, 16'd3);
        // Not-taken miss leaves the table alone
        upd(1'b1, 16'h0012, 1'b0, 16'h0, 16'h0013);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("ntmiss_keep", 16'h001A, 1'b1, 16'h0080);

        // Same-cycle lookup and update of 0x0012
        upd(1'b1, 16'h0012, 1'b1, 16'h0044, 16'h0013);
        look("same_old", 16'h0012, 1'b0, 16'h0013);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("same_new", 16'h0012, 1'b1, 16'h0044);
        look("same_evict", 16'h001A, 1'b0, 16'h001B);
        chk("same_cnt", mispredict_cnt, 16'd4);

        // Counter floor: 2 -> 1 -> 0 -> 0, then taken -> 1 (still not taken), taken -> 2
        for (int i = 0; i < 3; i++) begin
            upd(1'b1, 16'h0012, 1'b0, 16'h0, 16'h0013);
            tick();
        end
        upd(1'b1, 16'h0012, 1'b1, 16'h0044, 16'h0044);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("floor_sat", 16'h0012, 1'b0, 16'h0013);
        upd(1'b1, 16'h0012, 1'b1, 16'h0044, 16'h0044);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("floor_up", 16'h0012, 1'b1, 16'h0044);
        chk("floor_cnt", mispredict_cnt, 16'd4);

        // Flush beats a simultaneous update; the mispredict still counts
        upd(1'b1, 16'h001A, 1'b1, 16'h00A0, 16'h001B);
        flush_all = 1'b1;
        #1 chk("flush_mp", mispredict, 1'b1);
        tick();
        flush_all = 1'b0;
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("flush_12", 16'h0012, 1'b0, 16'h0013);
        look("flush_1a", 16'h001A, 1'b0, 16'h001B);
        chk("flush_cnt", mispredict_cnt, 16'd5);

        // Repopulate, then reset mid-cycle with an update in flight
        upd(1'b1, 16'h0012, 1'b1, 16'h0044, 16'h0044);
        tick();
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        look("pre_rst", 16'h0012, 1'b1, 16'h0044);
        #2;
        upd(1'b1, 16'h001A, 1'b1, 16'h00B0, 16'h0000);
        rst = 1'b0;
        #1;
        chk("rst_mid_cnt", mispredict_cnt, 16'd0);
        chk("rst_mid_taken", pred_taken, 1'b0);
        chk("rst_mid_mp", mispredict, 1'b1);
        tick();
        chk("rst_hold_cnt", mispredict_cnt, 16'd0);
        #2;
        upd(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        tick();
        look("post_rst_12", 16'h0012, 1'b0, 16'h0013);
        look("post_rst_1a", 16'h001A, 1'b0, 16'h001B);
        chk("post_rst_cnt", mispredict_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
